test_modes_stim_chk: RTL and testbench

- Self-checking stimulus/response stage wrapped around the k8 all-modes benchmark core.
- Upstream: drives pseudo-random operands (a, b, cin) and logic inputs (e, f, g) into the core.
- Downstream: consumes the registered sum/cout and the x/y/z shift-chain taps, and compares them against internally delayed expected values.
- Reports pass/fail and an error count, so the benchmark can run standalone on the fabric.

---
 rtl/test_modes_stim_chk_if.sv | 28 ++
 rtl/test_modes_stim_chk.sv | 206 ++++++++++++++++++++
 tb/tb_test_modes_stim_chk.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/test_modes_stim_chk_if.sv
// Core-side bus of the all-modes stimulus/checker: operands and logic inputs out, results back in.
// Latency: none (wires only).
// Backpressure: none; the core consumes one vector per cycle unconditionally.
interface test_modes_stim_chk_if;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       cin_out;
    logic       e_out;
    logic       f_out;
    logic       g_out;
    logic [3:0] sum_in;
    logic       cout_in;
    logic       x_in;
    logic       y_in;
    logic       z_in;

    // Stimulus/checker side: drives the core inputs, observes its results.
    modport master (
        output a_out, b_out, cin_out, e_out, f_out, g_out,
        input  sum_in, cout_in, x_in, y_in, z_in
    );

    // Core side: the mirror image of the master.
    modport slave (
        input  a_out, b_out, cin_out, e_out, f_out, g_out,
        output sum_in, cout_in, x_in, y_in, z_in
    );
endinterface

// File: rtl/test_modes_stim_chk.sv
// Self-checking LFSR stimulus and delayed-expectation checker around the k8 all-modes core.
// Latency: first vector one cycle after start; done rises NUM_VECTORS+12 cycles after the first vector.
// Backpressure: none; one vector per RUN cycle, start ignored while busy.
module test_modes_stim_chk #(
    parameter int unsigned NUM_VECTORS = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    test_modes_stim_chk_if.master        bus,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [7:0]                   err_count,
    output logic [15:0]                  vec_count
);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] NV       = 16'(NUM_VECTORS);
    localparam logic [3:0]  DRAIN_LAST = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;
    logic [11:0] r_stim;
    logic [15:0] r_vec_cnt;
    logic [3:0]  r_drain_cnt;
    logic [7:0]  r_err_cnt;

    // Expected-value delay lines; stage n holds a vector issued n+1 cycles ago.
    logic [1:0]  r_sum_vld;
    logic [4:0]  r_sum_exp [2];
    logic [11:0] r_d_vld;
    logic [11:0] r_d_exp;

    logic        w_start_run;
    logic        w_last_vec;
    logic        w_drain_end;
    logic        w_vld_in;
    logic [4:0]  w_exp_sum;
    logic        w_exp_d;
    logic        w_err_sum;
    logic        w_err_x;
    logic        w_err_y;
    logic        w_err_z;
    logic        w_err_any;
    logic        w_busy;
    logic        w_done;

    // Galois step: shift right, fold in the tap mask when a one falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ 16'hB400;
        end
        return nxt;
    endfunction

    assign w_lfsr_nxt  = lfsr_step(r_lfsr);
    assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_vec  = (r_state == S_RUN) && (r_vec_cnt == NV);
    assign w_drain_end = (r_state == S_DRAIN) && (r_drain_cnt == DRAIN_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start only has an effect from IDLE or DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)       w_next = S_RUN;
            S_RUN:   if (w_last_vec)  w_next = S_DRAIN;
            S_DRAIN: if (w_drain_end) w_next = S_DONE;
            S_DONE:  if (start)       w_next = S_RUN;
            default:                  w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN, S_DRAIN: w_busy = 1'b1;
            S_DONE:         w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // LFSR and registered stimulus: r_lfsr always holds the vector currently on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
            r_stim <= '0;
        end else if (w_start_run) begin
            r_lfsr <= SEED;
            r_stim <= SEED[11:0];
        end else if (r_state == S_RUN) begin
            r_lfsr <= w_lfsr_nxt;
            r_stim <= w_last_vec ? 12'h000 : w_lfsr_nxt[11:0];
        end
    end

    // Issued-vector counter; the first vector is counted as it appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_cnt <= '0;
        end else if (w_start_run) begin
            r_vec_cnt <= 16'd1;
        end else if ((r_state == S_RUN) && !w_last_vec) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
        end
    end

    // Drain timer covering the deepest tap so every in-flight vector is checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (r_state == S_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + 4'd1;
        end else begin
            r_drain_cnt <= '0;
        end
    end

    assign bus.a_out   = r_stim[3:0];
    assign bus.b_out   = r_stim[7:4];
    assign bus.cin_out = r_stim[8];
    assign bus.e_out   = r_stim[9];
    assign bus.f_out   = r_stim[10];
    assign bus.g_out   = r_stim[11];

    // Expectations are derived from the registered outputs, i.e. exactly what the core sees.
    assign w_vld_in  = (r_state == S_RUN);
    assign w_exp_sum = {1'b0, r_stim[3:0]} + {1'b0, r_stim[7:4]} + {4'b0000, r_stim[8]};
    assign w_exp_d   = (r_stim[9] & r_stim[11]) | ~r_stim[10];

    // Two-deep line for the registered adder result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_vld    <= '0;
            r_sum_exp[0] <= '0;
            r_sum_exp[1] <= '0;
        end else begin
            r_sum_vld    <= {r_sum_vld[0], w_vld_in};
            r_sum_exp[0] <= w_exp_sum;
            r_sum_exp[1] <= r_sum_exp[0];
        end
    end

    // Twelve-deep line for the shift-chain data, tapped at 4, 8 and 12 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_vld <= '0;
            r_d_exp <= '0;
        end else begin
            r_d_vld <= {r_d_vld[10:0], w_vld_in};
            r_d_exp <= {r_d_exp[10:0], w_exp_d};
        end
    end

    assign w_err_sum = r_sum_vld[1] && ({bus.cout_in, bus.sum_in} != r_sum_exp[1]);
    assign w_err_x   = r_d_vld[3]   && (bus.x_in != r_d_exp[3]);
    assign w_err_y   = r_d_vld[7]   && (bus.y_in != r_d_exp[7]);
    assign w_err_z   = r_d_vld[11]  && (bus.z_in != r_d_exp[11]);
    assign w_err_any = w_err_sum | w_err_x | w_err_y | w_err_z;

    // At most one count per cycle regardless of how many groups fail; sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_start_run) begin
            r_err_cnt <= '0;
        end else if (w_err_any && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign pass      = w_done && (r_err_cnt == 8'd0);
    assign err_count = r_err_cnt;
    assign vec_count = r_vec_cnt;

endmodule

// File: tb/tb_test_modes_stim_chk.sv
module tb_test_modes_stim_chk;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start   [3];
    logic [1:0]  fault   [3];   // 0 ideal, 1 sum[0] inverted, 2 x stuck 0, 3 cout stuck 1
    logic        busy_o  [3];
    logic        done_o  [3];
    logic        pass_o  [3];
    logic [7:0]  err_o   [3];
    logic [15:0] vec_o   [3];
    logic [11:0] stim_o  [3];

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    test_modes_stim_chk_if bus [3] ();

    test_modes_stim_chk #(.NUM_VECTORS(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .bus(bus[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_count(err_o[0]), .vec_count(vec_o[0])
    );
    test_modes_stim_chk #(.NUM_VECTORS(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .bus(bus[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_count(err_o[1]), .vec_count(vec_o[1])
    );
    test_modes_stim_chk #(.NUM_VECTORS(300)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .bus(bus[2]),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
        .err_count(err_o[2]), .vec_count(vec_o[2])
    );

    // Behavioural k8 core per instance, with optional planted faults on its outputs.
    for (genvar i = 0; i < 3; i++) begin : g_core
        logic [4:0]  s0 = '0;
        logic [4:0]  s1 = '0;
        logic [11:0] ch = '0;
        always @(posedge clk) begin
            s0 <= {1'b0, bus[i].a_out} + {1'b0, bus[i].b_out} + {4'b0000, bus[i].cin_out};
            s1 <= s0;
            ch <= {ch[10:0], (bus[i].e_out & bus[i].g_out) | ~bus[i].f_out};
        end
        assign bus[i].sum_in  = s1[3:0] ^ {3'b000, (fault[i] == 2'd1)};
        assign bus[i].cout_in = (fault[i] == 2'd3) ? 1'b1 : s1[4];
        assign bus[i].x_in    = (fault[i] == 2'd2) ? 1'b0 : ch[3];
        assign bus[i].y_in    = ch[7];
        assign bus[i].z_in    = ch[11];
        assign stim_o[i] = {bus[i].g_out, bus[i].f_out, bus[i].e_out,
                            bus[i].cin_out, bus[i].b_out, bus[i].a_out};
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Expected error count: walk the vector list and apply the fault's effect per vector.
    function automatic int exp_err(input logic [1:0] mode, input int nv);
        logic [15:0] l;
        int n;
        int s;
        logic d;
        l = SEED;
        n = 0;
        for (int j = 0; j < nv; j++) begin
            s = int'(l[3:0]) + int'(l[7:4]) + int'(l[8]);
            d = (l[9] & l[11]) | ~l[10];
            case (mode)
                2'd1: n++;
                2'd2: if (d) n++;
                2'd3: if (s < 16) n++;
                default: ;
            endcase
            l = lfsr_next(l);
        end
        return (n > 255) ? 255 : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input int idx);
        chk("idle_stim", 32'(stim_o[idx]), 32'd0);
        chk("idle_busy", 32'(busy_o[idx]), 32'd0);
        chk("idle_done", 32'(done_o[idx]), 32'd0);
        chk("idle_pass", 32'(pass_o[idx]), 32'd0);
        chk("idle_err",  32'(err_o[idx]),  32'd0);
        chk("idle_vec",  32'(vec_o[idx]),  32'd0);
    endtask

    // Full run from IDLE/DONE, called and returning on a falling edge.
    task automatic run(input int idx, input int nv, input bit noise);
        logic [15:0] l;
        int c;
        int bc;
        int ee;
        l  = SEED;
        ee = exp_err(fault[idx], nv);
        start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
        c  = 1;
        bc = 0;
        while (!done_o[idx] && c < nv + 40) begin
            if (c <= nv) begin
                chk("stim_vec", 32'(stim_o[idx]), 32'(l[11:0]));
                l = lfsr_next(l);
            end else begin
                chk("stim_drain", 32'(stim_o[idx]), 32'd0);
            end
            chk("vec_count_run", 32'(vec_o[idx]), 32'((c <= nv) ? c : nv));
            if (busy_o[idx]) bc++;
            if (noise) start[idx] = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            c++;
        end
        start[idx] = 1'b0;
        chk("done_latency", 32'(c),  32'(nv + 13));
        chk("busy_cycles",  32'(bc), 32'(nv + 12));
        chk("done",      32'(done_o[idx]), 32'd1);
        chk("busy_done", 32'(busy_o[idx]), 32'd0);
        chk("err_count", 32'(err_o[idx]),  32'(ee));
        chk("pass",      32'(pass_o[idx]), 32'(ee == 0));
        chk("vec_final", 32'(vec_o[idx]),  32'(nv));
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            fault[i] = 2'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i);
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal core, four vectors: timing, pass, counts, then DONE holds.
        run(0, 4, 1'b0);
        repeat (5) @(negedge clk);
        chk("done_hold", 32'(done_o[0]), 32'd1);
        chk("vec_hold",  32'(vec_o[0]),  32'd4);

        // Inverted sum bit: every vector counts once.
        fault[1] = 2'd1;
        run(1, 16, 1'b0);
        // Restart from DONE with x stuck at 0; also re-checks the identical sequence.
        fault[1] = 2'd2;
        run(1, 16, 1'b1);

        // Mid-run reset on vector 5, then a clean restart from the seed.
        fault[1] = 2'd0;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        chk("first_a", 32'(stim_o[1][3:0]), 32'h1);
        chk("first_b", 32'(stim_o[1][7:4]), 32'hE);
        repeat (5) @(negedge clk);
        chk("vec_at_5", 32'(vec_o[1]), 32'd6);
        rst_n = 1'b0;
        #1;
        chk_idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle(1);
        run(1, 16, 1'b0);

        // Random faults, idle gaps and spurious start pulses during RUN/DRAIN.
        for (int r = 0; r < 4; r++) begin
            fault[1] = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run(1, 16, 1'b1);
        end

        // Long runs: cout stuck at 1, then an always-failing fault to hit saturation.
        fault[2] = 2'd3;
        run(2, 300, 1'b0);
        fault[2] = 2'd1;
        run(2, 300, 1'b1);
        chk("err_saturated", 32'(err_o[2]), 32'd255);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
